pc_unit: RTL and testbench

- Program-counter and branch unit: the responder to the instruction controller's sCOU command strobe.
- Consumes command (mOperCOU, dataAddr, creg1, creg2, aeq) plus comparator flags; computes next PC.
- Holds a hardware return-address stack for CALL/RET and pulses pc_valid to the fetch stage whenever a new PC is ready.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/pc_unit_if.sv | 37 +++
 rtl/ret_stack.sv | 59 +++++
 rtl/pc_unit.sv | 146 ++++++++++++++
 tb/tb_pc_unit.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction controller and the PC/branch unit:
// command opcodes carried on mOperCOU, the PC unit state encoding and the
// branch condition helper.
package cpu_pkg;

  localparam logic [3:0] COU_JEQ  = 4'd1;
  localparam logic [3:0] COU_JGT  = 4'd2;
  localparam logic [3:0] COU_JLT  = 4'd3;
  localparam logic [3:0] COU_JMP  = 4'd5;
  localparam logic [3:0] COU_NEXT = 4'd6;
  localparam logic [3:0] COU_CALL = 4'd7;
  localparam logic [3:0] COU_RET  = 4'd8;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_RET_RD = 2'd2
  } cou_state_e;

  // Branch decision for the conditional jumps; aeq widens JGT/JLT to >= / <=.
  function automatic logic branch_taken(input logic [3:0] op,
                                        input logic aeq,
                                        input logic eq,
                                        input logic gt,
                                        input logic lt);
    logic taken;
    taken = 1'b0;
    case (op)
      COU_JEQ: taken = eq;
      COU_JGT: taken = gt | (aeq & eq);
      COU_JLT: taken = lt | (aeq & eq);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Command/response bundle between the instruction controller (master) and
// the PC/branch unit (slave).
interface pc_unit_if #(
  parameter int AW    = 15,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic          sCOU;
  logic [3:0]    mOperCOU;
  logic [AW-1:0] dataAddr;
  logic [1:0]    creg1;
  logic [1:0]    creg2;
  logic          aeq;
  logic          cmp_eq;
  logic          cmp_gt;
  logic          cmp_lt;
  logic          prst;

  logic [AW-1:0] pc;
  logic          pc_valid;
  logic          busy;
  logic          stack_err;
  logic [DW-1:0] depth;

  modport master (
    output sCOU, mOperCOU, dataAddr, creg1, creg2, aeq,
           cmp_eq, cmp_gt, cmp_lt, prst,
    input  pc, pc_valid, busy, stack_err, depth
  );

  modport slave (
    input  sCOU, mOperCOU, dataAddr, creg1, creg2, aeq,
           cmp_eq, cmp_gt, cmp_lt, prst,
    output pc, pc_valid, busy, stack_err, depth
  );
endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO: synchronous push, registered read of the top entry,
// and a separate pop that only moves the pointer. The pointer equals the
// occupancy and doubles as the write index.
module ret_stack #(
  parameter int AW    = 15,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int DW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [AW-1:0] push_data,
  input  logic          rd_req,
  input  logic          pop,
  output logic [AW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] top_idx;

  assign full    = (depth == DW'(DEPTH));
  assign empty   = (depth == '0);
  assign wr_idx  = depth[PW-1:0];
  assign top_idx = wr_idx - PW'(1);

  // Occupancy pointer: clear wins, then push, then pop.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      depth <= '0;
    end else if (clr) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DW'(1);
    end else if (pop && !empty) begin
      depth <= depth - DW'(1);
    end
  end

  // Storage and registered top-of-stack read.
  always_ff @(posedge clk) begin
    // NOTE: the array and read register have no reset; only the pointer
    // defines which entries are meaningful, so resetting data buys nothing.
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
    if (rd_req && !empty) begin
      rd_data <= mem[top_idx];
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter and branch unit. Responds to the controller's sCOU strobe
// with a new PC one cycle later (two for RET, which reads the return stack),
// flagged by a single-cycle pc_valid pulse.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int AW    = 15,
  parameter int DEPTH = 8,
  localparam int DW   = $clog2(DEPTH) + 1
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);

  cou_state_e    state, state_n;
  logic [AW-1:0] pc_q, pc_n;
  logic          valid_q, valid_n;
  logic          err_q, err_n;

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] tgt;
  logic          stk_push, stk_rd, stk_pop, stk_clr;
  logic          stk_full, stk_empty;
  logic [AW-1:0] stk_rd_data;
  logic [DW-1:0] stk_depth;

  // creg1[1] and creg2 are reserved bits of the command word.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{bus.creg1[1], bus.creg2};

  assign pc_inc = pc_q + AW'(1);
  assign tgt    = bus.creg1[0] ? (pc_q + bus.dataAddr) : bus.dataAddr;

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .clr       (stk_clr),
    .push      (stk_push),
    .push_data (pc_inc),
    .rd_req    (stk_rd),
    .pop       (stk_pop),
    .rd_data   (stk_rd_data),
    .full      (stk_full),
    .empty     (stk_empty),
    .depth     (stk_depth)
  );

  // Next-state, next-PC and stack control; prst overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    state_n  = state;
    pc_n     = pc_q;
    valid_n  = 1'b0;
    err_n    = err_q;
    stk_push = 1'b0;
    stk_rd   = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;

    if (bus.prst) begin
      state_n = ST_START;
      pc_n    = '0;
      err_n   = 1'b0;
      stk_clr = 1'b1;
    end else begin
      case (state)
        ST_START: begin
          valid_n = 1'b1;
          state_n = ST_IDLE;
        end

        ST_IDLE: begin
          if (bus.sCOU) begin
            valid_n = 1'b1;
            case (bus.mOperCOU)
              COU_JMP: pc_n = tgt;
              COU_JEQ, COU_JGT, COU_JLT: begin
                pc_n = branch_taken(bus.mOperCOU, bus.aeq, bus.cmp_eq,
                                    bus.cmp_gt, bus.cmp_lt) ? tgt : pc_inc;
              end
              COU_CALL: begin
                if (stk_full) begin
                  err_n = 1'b1;
                  pc_n  = pc_inc;
                end else begin
                  stk_push = 1'b1;
                  pc_n     = tgt;
                end
              end
              COU_RET: begin
                if (stk_empty) begin
                  err_n = 1'b1;
                  pc_n  = pc_inc;
                end else begin
                  valid_n = 1'b0;
                  stk_rd  = 1'b1;
                  state_n = ST_RET_RD;
                end
              end
              default: pc_n = pc_inc;
            endcase
          end
        end

        ST_RET_RD: begin
          if (bus.sCOU) begin
            err_n = 1'b1;
          end
          pc_n    = stk_rd_data;
          stk_pop = 1'b1;
          valid_n = 1'b1;
          state_n = ST_IDLE;
        end

        default: state_n = ST_START;
      endcase
    end
  end

  // State, PC, valid pulse and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_START;
      pc_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = valid_q;
  assign bus.busy      = (state == ST_RET_RD);
  assign bus.stack_err = err_q;
  assign bus.depth     = stk_depth;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset start-up, sequential fetch, conditional
// branches, wrap-around, CALL/RET with the return stack, stack errors,
// strobes while busy and program restart.
module tb_pc_unit;
  import cpu_pkg::*;

  localparam int AW    = 15;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_unit_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  pc_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One strobe with an idle gap before it; returns #1 after the sampling edge.
  task automatic cmd(input logic [3:0] op, input logic [AW-1:0] addr,
                     input logic rel, input logic a, input logic eq,
                     input logic gt, input logic lt);
    @(negedge clk);
    @(negedge clk);
    bus.mOperCOU = op;
    bus.dataAddr = addr;
    bus.creg1    = {1'b0, rel};
    bus.aeq      = a;
    bus.cmp_eq   = eq;
    bus.cmp_gt   = gt;
    bus.cmp_lt   = lt;
    bus.sCOU     = 1'b1;
    @(posedge clk);
    #1;
    bus.sCOU     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    @(negedge clk);
    bus.prst = 1'b1;
    @(posedge clk);
    #1;
    bus.prst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    if ({bus.pc_valid, bus.busy, bus.stack_err, bus.depth, bus.pc} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%0b b=%0b e=%0b d=%0d pc=%h exp all zero",
               bus.pc_valid, bus.busy, bus.stack_err, bus.depth, bus.pc);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    if ({bus.pc_valid, bus.pc} !== {1'b1, 15'h0000}) begin
      errors++;
      $display("FAIL start_pulse got v=%0b pc=%h exp v=1 pc=0000", bus.pc_valid, bus.pc);
    end
    checks++;
    tick();
    if (bus.pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_single got v=%0b exp v=0", bus.pc_valid);
    end
    checks++;
  endtask

  task automatic test_next();
    for (int i = 1; i <= 3; i++) begin
      cmd(COU_NEXT, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if ({bus.pc_valid, bus.pc} !== {1'b1, AW'(i)}) begin
        errors++;
        $display("FAIL next_%0d got v=%0b pc=%h exp v=1 pc=%h", i, bus.pc_valid, bus.pc, AW'(i));
      end
      checks++;
    end
    tick();
    if ({bus.pc_valid, bus.pc} !== {1'b0, 15'h0003}) begin
      errors++;
      $display("FAIL next_pulse_end got v=%0b pc=%h exp v=0 pc=0003", bus.pc_valid, bus.pc);
    end
    checks++;
  endtask

  task automatic test_cond_branch();
    logic [AW-1:0] exp_pc [8];
    exp_pc = '{15'h0010, 15'h0011, 15'h0010, 15'h0100,
               15'h0300, 15'h0301, 15'h0050, 15'h0051};
    cmd(COU_JMP, 15'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (bus.pc !== exp_pc[0]) begin
      errors++; $display("FAIL jmp_abs got pc=%h exp %h", bus.pc, exp_pc[0]);
    end
    checks++;
    cmd(COU_JEQ, 15'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({bus.pc_valid, bus.pc} !== {1'b1, exp_pc[1]}) begin
      errors++; $display("FAIL jeq_not_taken got v=%0b pc=%h exp v=1 pc=%h", bus.pc_valid, bus.pc, exp_pc[1]);
    end
    checks++;
    cmd(COU_JMP, 15'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd(COU_JEQ, 15'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    if (bus.pc !== exp_pc[3]) begin
      errors++; $display("FAIL jeq_taken got pc=%h exp %h", bus.pc, exp_pc[3]);
    end
    checks++;
    cmd(COU_JGT, 15'h0300, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    if (bus.pc !== exp_pc[4]) begin
      errors++; $display("FAIL jgt_aeq_taken got pc=%h exp %h", bus.pc, exp_pc[4]);
    end
    checks++;
    cmd(COU_JGT, 15'h0400, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    if (bus.pc !== exp_pc[5]) begin
      errors++; $display("FAIL jgt_eq_no_aeq got pc=%h exp %h", bus.pc, exp_pc[5]);
    end
    checks++;
    cmd(COU_JLT, 15'h0050, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (bus.pc !== exp_pc[6]) begin
      errors++; $display("FAIL jlt_taken got pc=%h exp %h", bus.pc, exp_pc[6]);
    end
    checks++;
    cmd(COU_JLT, 15'h0060, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    if (bus.pc !== exp_pc[7]) begin
      errors++; $display("FAIL jlt_gt_not_taken got pc=%h exp %h", bus.pc, exp_pc[7]);
    end
    checks++;
    cmd(4'd4, 15'h0777, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    if (bus.pc !== 15'h0052) begin
      errors++; $display("FAIL unknown_op got pc=%h exp 0052", bus.pc);
    end
    checks++;
  endtask

  task automatic test_wrap();
    cmd(COU_JMP, 15'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd(COU_NEXT, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({bus.pc_valid, bus.pc} !== {1'b1, 15'h0000}) begin
      errors++; $display("FAIL next_wrap got v=%0b pc=%h exp v=1 pc=0000", bus.pc_valid, bus.pc);
    end
    checks++;
    cmd(COU_JMP, 15'h7FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd(COU_JMP, 15'h0020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (bus.pc !== 15'h0010) begin
      errors++; $display("FAIL rel_wrap got pc=%h exp 0010", bus.pc);
    end
    checks++;
  endtask

  task automatic test_call_ret();
    cmd(COU_JMP, 15'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd(COU_CALL, 15'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({bus.pc_valid, bus.depth, bus.pc} !== {1'b1, 4'd1, 15'h0200}) begin
      errors++; $display("FAIL call got v=%0b d=%0d pc=%h exp v=1 d=1 pc=0200", bus.pc_valid, bus.depth, bus.pc);
    end
    checks++;
    cmd(COU_RET, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({bus.busy, bus.pc_valid, bus.pc} !== {1'b1, 1'b0, 15'h0200}) begin
      errors++; $display("FAIL ret_busy got b=%0b v=%0b pc=%h exp b=1 v=0 pc=0200", bus.busy, bus.pc_valid, bus.pc);
    end
    checks++;
    tick();
    if ({bus.busy, bus.pc_valid, bus.depth, bus.pc} !== {1'b0, 1'b1, 4'd0, 15'h0006}) begin
      errors++; $display("FAIL ret_done got b=%0b v=%0b d=%0d pc=%h exp b=0 v=1 d=0 pc=0006", bus.busy, bus.pc_valid, bus.depth, bus.pc);
    end
    checks++;
  endtask

  task automatic test_overflow();
    cmd(COU_JMP, 15'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cmd(COU_CALL, AW'(16'h1000 + i * 16'h0100), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if ({bus.depth, bus.stack_err, bus.pc} !== {4'd8, 1'b0, 15'h1700}) begin
      errors++; $display("FAIL calls_full got d=%0d e=%0b pc=%h exp d=8 e=0 pc=1700", bus.depth, bus.stack_err, bus.pc);
    end
    checks++;
    cmd(COU_CALL, 15'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({bus.pc_valid, bus.depth, bus.stack_err, bus.pc} !== {1'b1, 4'd8, 1'b1, 15'h1701}) begin
      errors++; $display("FAIL call_overflow got v=%0b d=%0d e=%0b pc=%h exp v=1 d=8 e=1 pc=1701", bus.pc_valid, bus.depth, bus.stack_err, bus.pc);
    end
    checks++;
    cmd(COU_RET, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if ({bus.depth, bus.pc} !== {4'd7, 15'h1601}) begin
      errors++; $display("FAIL lifo_ret1 got d=%0d pc=%h exp d=7 pc=1601", bus.depth, bus.pc);
    end
    checks++;
    cmd(COU_RET, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if ({bus.depth, bus.pc} !== {4'd6, 15'h1501}) begin
      errors++; $display("FAIL lifo_ret2 got d=%0d pc=%h exp d=6 pc=1501", bus.depth, bus.pc);
    end
    checks++;
    restart();
    if ({bus.pc_valid, bus.depth, bus.stack_err, bus.pc} !== '0) begin
      errors++; $display("FAIL prst_clear got v=%0b d=%0d e=%0b pc=%h exp all zero", bus.pc_valid, bus.depth, bus.stack_err, bus.pc);
    end
    checks++;
    tick();
    if ({bus.pc_valid, bus.pc} !== {1'b1, 15'h0000}) begin
      errors++; $display("FAIL prst_start got v=%0b pc=%h exp v=1 pc=0000", bus.pc_valid, bus.pc);
    end
    checks++;
  endtask

  task automatic test_underflow();
    cmd(COU_RET, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({bus.pc_valid, bus.busy, bus.stack_err, bus.depth, bus.pc} !== {1'b1, 1'b0, 1'b1, 4'd0, 15'h0001}) begin
      errors++; $display("FAIL ret_underflow got v=%0b b=%0b e=%0b d=%0d pc=%h exp v=1 b=0 e=1 d=0 pc=0001", bus.pc_valid, bus.busy, bus.stack_err, bus.depth, bus.pc);
    end
    checks++;
  endtask

  task automatic test_busy_strobe();
    restart();
    tick();
    cmd(COU_JMP, 15'h0020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd(COU_CALL, 15'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd(COU_RET, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.mOperCOU = COU_NEXT;
    bus.sCOU     = 1'b1;
    tick();
    bus.sCOU     = 1'b0;
    if ({bus.pc_valid, bus.busy, bus.stack_err, bus.depth, bus.pc} !== {1'b1, 1'b0, 1'b1, 4'd0, 15'h0021}) begin
      errors++; $display("FAIL strobe_while_busy got v=%0b b=%0b e=%0b d=%0d pc=%h exp v=1 b=0 e=1 d=0 pc=0021", bus.pc_valid, bus.busy, bus.stack_err, bus.depth, bus.pc);
    end
    checks++;
    tick();
    if ({bus.pc_valid, bus.pc} !== {1'b0, 15'h0021}) begin
      errors++; $display("FAIL busy_strobe_dropped got v=%0b pc=%h exp v=0 pc=0021", bus.pc_valid, bus.pc);
    end
    checks++;
  endtask

  task automatic test_prst_mid_ret();
    cmd(COU_CALL, 15'h0080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd(COU_RET, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.prst = 1'b1;
    tick();
    bus.prst = 1'b0;
    if ({bus.pc_valid, bus.busy, bus.stack_err, bus.depth, bus.pc} !== '0) begin
      errors++; $display("FAIL prst_mid_ret got v=%0b b=%0b e=%0b d=%0d pc=%h exp all zero", bus.pc_valid, bus.busy, bus.stack_err, bus.depth, bus.pc);
    end
    checks++;
    tick();
    if ({bus.pc_valid, bus.pc} !== {1'b1, 15'h0000}) begin
      errors++; $display("FAIL prst_mid_ret_start got v=%0b pc=%h exp v=1 pc=0000", bus.pc_valid, bus.pc);
    end
    checks++;
    cmd(COU_NEXT, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if ({bus.pc_valid, bus.pc} !== {1'b1, 15'h0001}) begin
      errors++; $display("FAIL after_prst_next got v=%0b pc=%h exp v=1 pc=0001", bus.pc_valid, bus.pc);
    end
    checks++;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.sCOU     = 1'b0;
    bus.mOperCOU = 4'd0;
    bus.dataAddr = '0;
    bus.creg1    = 2'b00;
    bus.creg2    = 2'b00;
    bus.aeq      = 1'b0;
    bus.cmp_eq   = 1'b0;
    bus.cmp_gt   = 1'b0;
    bus.cmp_lt   = 1'b0;
    bus.prst     = 1'b0;

    test_reset();
    test_next();
    test_cond_branch();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_busy_strobe();
    test_prst_mid_ret();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
